// File: rtl/c2c_tg_pkg.sv
// Shared definitions for the C2C AXI4-Lite traffic generator: FSM states,
// response encoding and the data pattern written to the remote window.
package c2c_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DATA
    } tg_state_t;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    function automatic logic [31:0] tg_pattern(input logic [15:0] pass, input logic [15:0] idx);
        return {pass ^ 16'hA5A5, idx};
    endfunction

endpackage

// File: rtl/c2c_traffic_gen_if.sv
// AXI4-Lite bundle between the traffic generator and the C2C master slave port.
interface c2c_traffic_gen_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/c2c_tg_watchdog.sv
// Stall watchdog: counts consecutive waiting cycles, pulses expired once per stall.
module c2c_tg_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Counter parks at TIMEOUT so a long stall reports only once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (kick || !run)
            cnt <= '0;
        else if (cnt != CW'(TIMEOUT))
            cnt <= cnt + CW'(1);
    end

    assign expired = run && !kick && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/c2c_traffic_gen.sv
// Writes a pass-tagged pattern across a remote window, reads it back and checks it;
// one AXI4-Lite transaction outstanding at a time.
module c2c_traffic_gen
    import c2c_tg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic              link_up,
    input  logic              clear,
    c2c_traffic_gen_if.master m_axi,
    output logic [31:0]       pass_count,
    output logic [31:0]       err_count,
    output logic              busy,
    output logic [3:0]        led_out
);
    tg_state_t   state, state_n;
    logic [15:0] idx, idx_n;
    logic [15:0] tag, tag_n;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic        awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic        err_hit, pass_done, last_word;
    logic        wd_run, wd_kick, wd_expired;
    logic        heartbeat, timeout_flag;
    logic [1:0]  err_inc;
    logic [32:0] err_sum;

    assign last_word = (idx == 16'(NUM_WORDS - 1));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state <= IDLE;
        else        state <= state_n;
    end

    // Handshake outputs are registered, so each is computed for the state being entered.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        tag_n     = tag;
        awvalid_n = 1'b0;
        wvalid_n  = 1'b0;
        bready_n  = 1'b0;
        arvalid_n = 1'b0;
        rready_n  = 1'b0;
        err_hit   = 1'b0;
        pass_done = 1'b0;
        unique case (state)
            IDLE: if (enable && link_up) begin
                state_n   = WR;
                idx_n     = '0;
                tag_n     = pass_count[15:0];
                awvalid_n = 1'b1;
                wvalid_n  = 1'b1;
            end
            WR: begin
                awvalid_n = awvalid_q && !m_axi.awready;
                wvalid_n  = wvalid_q && !m_axi.wready;
                if (!awvalid_n && !wvalid_n) begin
                    state_n  = WR_RESP;
                    bready_n = 1'b1;
                end
            end
            WR_RESP: if (m_axi.bvalid) begin
                err_hit = (m_axi.bresp != AXI_RESP_OKAY);
                if (last_word) begin
                    state_n   = RD;
                    idx_n     = '0;
                    arvalid_n = 1'b1;
                end else begin
                    state_n   = WR;
                    idx_n     = idx + 16'd1;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                end
            end else begin
                bready_n = 1'b1;
            end
            RD: if (m_axi.arready) begin
                state_n  = RD_DATA;
                rready_n = 1'b1;
            end else begin
                arvalid_n = 1'b1;
            end
            RD_DATA: if (m_axi.rvalid) begin
                err_hit = (m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rdata != tg_pattern(tag, idx));
                if (last_word) begin
                    state_n   = IDLE;
                    pass_done = 1'b1;
                end else begin
                    state_n   = RD;
                    idx_n     = idx + 16'd1;
                    arvalid_n = 1'b1;
                end
            end else begin
                rready_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx       <= '0;
            tag       <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
            wstrb_q   <= '0;
            busy      <= 1'b0;
        end else begin
            idx       <= idx_n;
            tag       <= tag_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            arvalid_q <= arvalid_n;
            rready_q  <= rready_n;
            wstrb_q   <= 4'hF;
            busy      <= (state_n != IDLE);
            if (state_n == WR && state != WR) begin
                awaddr_q <= BASE_ADDR + {14'd0, idx_n, 2'b00};
                wdata_q  <= tg_pattern(tag_n, idx_n);
            end
            if (state_n == RD && state != RD)
                araddr_q <= BASE_ADDR + {14'd0, idx_n, 2'b00};
        end
    end

    assign wd_run  = (awvalid_q && !m_axi.awready) || (wvalid_q && !m_axi.wready) ||
                     (bready_q && !m_axi.bvalid) || (arvalid_q && !m_axi.arready) ||
                     (rready_q && !m_axi.rvalid);
    assign wd_kick = (awvalid_q && m_axi.awready) || (wvalid_q && m_axi.wready) ||
                     (bready_q && m_axi.bvalid) || (arvalid_q && m_axi.arready) ||
                     (rready_q && m_axi.rvalid);

    c2c_tg_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (aclk),
        .rst     (areset),
        .run     (wd_run),
        .kick    (wd_kick),
        .expired (wd_expired)
    );

    // A data error and a timeout can land in the same cycle; add both, then saturate.
    assign err_inc = {1'b0, err_hit} + {1'b0, wd_expired};
    assign err_sum = {1'b0, err_count} + 33'(err_inc);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pass_count   <= '0;
            err_count    <= '0;
            heartbeat    <= 1'b0;
            timeout_flag <= 1'b0;
            led_out      <= '0;
        end else begin
            if (clear) begin
                pass_count   <= '0;
                err_count    <= '0;
                heartbeat    <= 1'b0;
                timeout_flag <= 1'b0;
            end else begin
                if (pass_done) begin
                    pass_count <= pass_count + 32'd1;
                    heartbeat  <= !heartbeat;
                end
                if (wd_expired)
                    timeout_flag <= 1'b1;
                err_count <= err_sum[32] ? '1 : err_sum[31:0];
            end
            led_out <= {timeout_flag, (err_count != '0), heartbeat, link_up};
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_c2c_traffic_gen.sv
// Directed bench for c2c_traffic_gen with a reactive AXI4-Lite memory slave.
module tb_c2c_traffic_gen;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int NW = 4;
    localparam int TO = 16;

    logic        aclk = 1'b0;
    logic        areset, enable, link_up, clear;
    logic [31:0] pass_count, err_count;
    logic        busy;
    logic [3:0]  led_out;

    c2c_traffic_gen_if axi ();

    c2c_traffic_gen #(.BASE_ADDR(BASE), .NUM_WORDS(NW), .TIMEOUT(TO)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .enable     (enable),
        .link_up    (link_up),
        .clear      (clear),
        .m_axi      (axi),
        .pass_count (pass_count),
        .err_count  (err_count),
        .busy       (busy),
        .led_out    (led_out)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Slave model state
    logic [31:0] mem [NW];
    bit          mode_rand = 0, flip_w2 = 0, slverr_w1 = 0, hold_aw = 0;
    int          viol = 0, rd_cnt = 0, rd_w1_cnt = 0;
    logic        p_awv, p_wv, p_bv, p_arv, p_rr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic        got_aw, got_w, b_pend, r_pend;
    logic [31:0] s_waddr, s_wdata, r_addr, off;
    int          b_wait, r_wait, widx;

    // Acts at negedge: handshakes seen are those of the posedge just gone.
    always @(negedge aclk) begin
        if (areset) begin
            axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
            axi.bvalid = 1'b0; axi.rvalid = 1'b0;
            axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
            p_awv = 1'b0; p_wv = 1'b0; p_bv = 1'b0; p_arv = 1'b0; p_rr = 1'b0;
            got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
        end else begin
            if (p_awv && axi.awready) begin got_aw = 1'b1; s_waddr = p_awaddr; end
            else if (p_awv && (!axi.awvalid || axi.awaddr != p_awaddr)) viol++;
            if (p_wv && axi.wready) begin got_w = 1'b1; s_wdata = p_wdata; end
            else if (p_wv && (!axi.wvalid || axi.wdata != p_wdata)) viol++;
            if (p_arv && axi.arready) begin
                r_pend = 1'b1; r_addr = p_araddr; rd_cnt++;
                r_wait = mode_rand ? int'($urandom_range(0, 3)) : 0;
                if (p_araddr == BASE + 32'd4) rd_w1_cnt++;
            end else if (p_arv && (!axi.arvalid || axi.araddr != p_araddr)) viol++;
            if (p_bv && axi.bvalid) axi.bvalid = 1'b0;
            if (p_rr && axi.rvalid) axi.rvalid = 1'b0;
            if (got_aw && got_w) begin
                off = s_waddr - BASE;
                widx = int'(off[31:2]);
                if (off[1:0] != 2'b00 || off >= 32'(4 * NW)) viol++;
                else mem[widx] = s_wdata;
                axi.bresp = (slverr_w1 && widx == 1) ? 2'b10 : 2'b00;
                got_aw = 1'b0; got_w = 1'b0; b_pend = 1'b1;
                b_wait = mode_rand ? int'($urandom_range(0, 3)) : 0;
            end
            if (b_pend) begin
                if (b_wait == 0) begin axi.bvalid = 1'b1; b_pend = 1'b0; end
                else b_wait--;
            end
            if (r_pend) begin
                if (r_wait == 0) begin
                    off = r_addr - BASE;
                    widx = int'(off[31:2]);
                    if (off[1:0] != 2'b00 || off >= 32'(4 * NW)) begin viol++; axi.rdata = '0; end
                    else axi.rdata = mem[widx] ^ ((flip_w2 && widx == 2) ? 32'h1 : 32'h0);
                    axi.rresp = 2'b00; axi.rvalid = 1'b1; r_pend = 1'b0;
                end else r_wait--;
            end
            axi.awready = !hold_aw && (!mode_rand || $urandom_range(0, 3) != 0);
            axi.wready  = !mode_rand || $urandom_range(0, 3) != 0;
            axi.arready = !mode_rand || $urandom_range(0, 3) != 0;
            p_awv = axi.awvalid; p_wv = axi.wvalid; p_bv = axi.bready;
            p_arv = axi.arvalid; p_rr = axi.rready;
            p_awaddr = axi.awaddr; p_wdata = axi.wdata; p_araddr = axi.araddr;
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic wait_pass(input logic [31:0] target, input int bound, output int at);
        int n = 0;
        while (pass_count !== target && n < bound) begin @(negedge aclk); n++; end
        at = cyc;
        chk("reach_pass", pass_count, target);
    endtask

    task automatic wait_busy(input logic v);
        int n = 0;
        while (busy !== v && n < 200) begin @(negedge aclk); n++; end
        chk("busy_wait", 32'(busy), 32'(v));
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
    endtask

    int c1, c2, c3, t, b0, b1, aw_hi, n;

    initial begin
        areset = 1'b1; enable = 1'b0; link_up = 1'b0; clear = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_pass", pass_count, 32'd0);
        chk("rst_err", err_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_led", 32'(led_out), 32'd0);
        chk("rst_handshakes", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Three passes against an always-ready slave
        link_up = 1'b1; enable = 1'b1;
        wait_pass(1, 200, c1);
        wait_pass(2, 200, c2);
        wait_busy(1'b1);
        enable = 1'b0;
        wait_pass(3, 200, c3);
        wait_busy(1'b0);
        repeat (2) @(negedge aclk);
        chk("pass_period_a", 32'(c2 - c1), 32'd17);
        chk("pass_period_b", 32'(c3 - c2), 32'd17);
        chk("basic_err", err_count, 32'd0);
        chk("basic_led", 32'(led_out), 32'b0011);
        chk("mem_word0", mem[0], 32'hA5A7_0000);
        chk("mem_word3", mem[3], 32'hA5A7_0003);
        repeat (10) @(negedge aclk);
        chk("idle_no_restart", pass_count, 32'd3);

        // Clear, then 100 passes with random back-pressure
        pulse_clear();
        chk("clear_pass", pass_count, 32'd0);
        @(negedge aclk);
        chk("clear_led", 32'(led_out), 32'b0001);
        mode_rand = 1; enable = 1'b1;
        wait_pass(99, 20000, t);
        wait_busy(1'b1);
        enable = 1'b0;
        wait_pass(100, 500, t);
        wait_busy(1'b0);
        mode_rand = 0;
        repeat (2) @(negedge aclk);
        chk("rand_err", err_count, 32'd0);
        chk("rand_protocol", 32'(viol), 32'd0);
        chk("rand_led", 32'(led_out), 32'b0001);

        // Bit 0 of word 2 flipped on readback
        pulse_clear();
        flip_w2 = 1; enable = 1'b1;
        wait_pass(1, 200, t);
        chk("flip_err_1", err_count, 32'd1);
        wait_busy(1'b1);
        enable = 1'b0;
        wait_pass(2, 200, t);
        wait_busy(1'b0);
        flip_w2 = 0;
        repeat (2) @(negedge aclk);
        chk("flip_err_2", err_count, 32'd2);
        chk("flip_led2", 32'(led_out[2]), 32'd1);

        // SLVERR on the write of word 1
        pulse_clear();
        slverr_w1 = 1; b0 = rd_cnt; b1 = rd_w1_cnt; enable = 1'b1;
        wait_busy(1'b1);
        enable = 1'b0;
        wait_pass(1, 200, t);
        wait_busy(1'b0);
        slverr_w1 = 0;
        repeat (2) @(negedge aclk);
        chk("slverr_err", err_count, 32'd1);
        chk("slverr_reads", 32'(rd_cnt - b0), 32'd4);
        chk("slverr_word1_read", 32'(rd_w1_cnt - b1), 32'd1);

        // awready held off for TIMEOUT+10 cycles
        pulse_clear();
        hold_aw = 1; enable = 1'b1;
        wait_busy(1'b1);
        aw_hi = 0;
        for (int i = 0; i < TO + 10; i++) begin
            aw_hi += int'(axi.awvalid);
            @(negedge aclk);
        end
        hold_aw = 0; enable = 1'b0;
        wait_pass(1, 200, t);
        wait_busy(1'b0);
        repeat (2) @(negedge aclk);
        chk("stall_awvalid_held", 32'(aw_hi), 32'(TO + 10));
        chk("stall_err", err_count, 32'd1);
        chk("stall_led", 32'(led_out), 32'b1111);
        chk("stall_protocol", 32'(viol), 32'd0);

        // link_up drops mid-pass; clear lands on the completing handshake
        b0 = rd_cnt;
        enable = 1'b1;
        wait_busy(1'b1);
        link_up = 1'b0;
        n = 0;
        while (!(axi.rready && axi.araddr == BASE + 32'd12) && n < 100) begin @(negedge aclk); n++; end
        chk("last_read_reached", 32'(axi.rready), 32'd1);
        clear = 1'b1;
        @(negedge aclk);
        clear = 1'b0;
        repeat (20) @(negedge aclk);
        chk("drop_pass", pass_count, 32'd0);
        chk("drop_err", err_count, 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_led", 32'(led_out), 32'd0);
        chk("drop_reads", 32'(rd_cnt - b0), 32'd4);
        enable = 1'b0;

        // Asynchronous reset in the middle of a pass
        link_up = 1'b1; enable = 1'b1;
        wait_busy(1'b1);
        repeat (5) @(negedge aclk);
        areset = 1'b1;
        #1;
        chk("midrst_handshakes", 32'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge aclk);
        enable = 1'b0; link_up = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
